// File: rtl/axi_pmu_sampler.sv
// Periodic / on-demand PMU snapshot sampler; streams each snapshot as 32-bit words.
// Optional checksum trailer word: define PMU_SAMPLER_CHECKSUM_EN.
module axi_pmu_sampler #(
    parameter int unsigned NUM_COUNTERS = 19,
    parameter int unsigned PERIOD_W     = 32
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                trigger_i,
    input  logic                clear_i,
    output logic [4:0]          pmu_addr_o,
    input  logic [63:0]         pmu_data_i,
    output logic [31:0]         out_data_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                busy_o,
    output logic                overrun_o,
    output logic [7:0]          seq_o
);

    localparam logic [4:0] LastIdx  = 5'(NUM_COUNTERS - 1);
    localparam logic [7:0] NumWords = 8'(NUM_COUNTERS);

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StFetch,
        StSendLo,
        StSendHi
`ifdef PMU_SAMPLER_CHECKSUM_EN
        , StTrailer
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [4:0]          idx_q, idx_d;
    logic [4:0]          addr_q, addr_d;
    logic [63:0]         hold_q, hold_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic [7:0]          seq_q, seq_d;
    logic                overrun_q, overrun_d;
    logic [31:0]         data_q, data_d;
    logic                valid_q, valid_d;
`ifdef PMU_SAMPLER_CHECKSUM_EN
    logic [31:0]         xor_q, xor_d;
`endif

    logic tick;
    logic hs;
    logic start;
    logic last;

    assign hs    = valid_q & out_ready_i;
    assign start = tick | trigger_i;
    assign last  = (idx_q == LastIdx);

    // The >= compare lets a lowered period fire on the very next cycle.
    always_comb begin
        tick    = 1'b0;
        timer_d = '0;
        if (period_i != '0) begin
            if (timer_q >= period_i - PERIOD_W'(1)) begin
                tick = 1'b1;
            end else begin
                timer_d = timer_q + PERIOD_W'(1);
            end
        end
    end

    always_comb begin
        overrun_d = overrun_q;
        if (clear_i) begin
            overrun_d = 1'b0;
        end
        if (tick && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
    end

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StHeader;
            StHeader: if (hs) state_d = StFetch;
            StFetch:  state_d = StSendLo;
            StSendLo: if (hs) state_d = StSendHi;
            StSendHi: begin
                if (hs) begin
`ifdef PMU_SAMPLER_CHECKSUM_EN
                    state_d = last ? StTrailer : StFetch;
`else
                    state_d = last ? StIdle : StFetch;
`endif
                end
            end
`ifdef PMU_SAMPLER_CHECKSUM_EN
            StTrailer: if (hs) state_d = StIdle;
`endif
            default:  state_d = StIdle;
        endcase
    end

    // Next values of the registered stream outputs and datapath
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        seq_d   = seq_q;
`ifdef PMU_SAMPLER_CHECKSUM_EN
        xor_d   = hs ? (xor_q ^ data_q) : xor_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    valid_d = 1'b1;
                    data_d  = {16'hA55A, seq_q, NumWords};
`ifdef PMU_SAMPLER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            StHeader: begin
                if (hs) begin
                    valid_d = 1'b0;
                    idx_d   = '0;
                    addr_d  = '0;
                end
            end
            StFetch: begin
                hold_d  = pmu_data_i;
                valid_d = 1'b1;
                data_d  = pmu_data_i[31:0];
            end
            StSendLo: begin
                if (hs) data_d = hold_q[63:32];
            end
            StSendHi: begin
                if (hs) begin
                    if (last) begin
`ifdef PMU_SAMPLER_CHECKSUM_EN
                        data_d  = xor_q ^ data_q;
`else
                        valid_d = 1'b0;
                        seq_d   = seq_q + 8'd1;
`endif
                    end else begin
                        valid_d = 1'b0;
                        idx_d   = idx_q + 5'd1;
                        addr_d  = idx_q + 5'd1;
                    end
                end
            end
`ifdef PMU_SAMPLER_CHECKSUM_EN
            StTrailer: begin
                if (hs) begin
                    valid_d = 1'b0;
                    seq_d   = seq_q + 8'd1;
                end
            end
`endif
            default: valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            seq_q     <= '0;
            timer_q   <= '0;
            overrun_q <= 1'b0;
`ifdef PMU_SAMPLER_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            seq_q     <= seq_d;
            timer_q   <= timer_d;
            overrun_q <= overrun_d;
`ifdef PMU_SAMPLER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign pmu_addr_o  = addr_q;
    assign seq_o       = seq_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_axi_pmu_sampler.sv
// Scoreboard bench for axi_pmu_sampler: expected words are queued on trigger/period
// setup and popped by a negedge monitor on every stream handshake.
module tb_axi_pmu_sampler;

    localparam int unsigned NC = 19;
`ifdef PMU_SAMPLER_CHECKSUM_EN
    localparam int FrameLen = 2 + 2 * NC;
`else
    localparam int FrameLen = 1 + 2 * NC;
`endif

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] period = '0;
    logic        trigger = 1'b0;
    logic        clear = 1'b0;
    logic [4:0]  pmu_addr;
    logic [63:0] pmu_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        overrun;
    logic [7:0]  seq;

    logic [63:0] flip_mask = '0;
    logic [31:0] addr32;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];
    logic [7:0]  exp_seq = '0;
    int          words_seen = 0;
    int          cyc = 0;
    logic        chk_spacing = 1'b0;
    int          last_hdr_cyc = -1;
    int          hdr_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    assign addr32   = {27'b0, pmu_addr};
    assign pmu_data = {addr32 + 32'h100, addr32} ^ flip_mask;

    axi_pmu_sampler #(.NUM_COUNTERS(NC), .PERIOD_W(32)) dut (
        .aclk        (aclk),
        .areset      (areset),
        .period_i    (period),
        .trigger_i   (trigger),
        .clear_i     (clear),
        .pmu_addr_o  (pmu_addr),
        .pmu_data_i  (pmu_data),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .busy_o      (busy),
        .overrun_o   (overrun),
        .seq_o       (seq)
    );

    // Stream monitor: scoreboard pop, stall stability, header spacing.
    always @(negedge aclk) begin
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_cmp++;
                if (!out_valid || out_data !== prev_data) begin
                    n_err++;
                    $display("FAIL stall_stable: valid=%b data=%h required valid=1 data=%h",
                             out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                words_seen++;
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL stream_word: got %h with no word expected", out_data);
                end else begin
                    logic [31:0] exp_w;
                    exp_w = sb_q.pop_front();
                    if (out_data !== exp_w) begin
                        n_err++;
                        $display("FAIL stream_word: got %h required %h", out_data, exp_w);
                    end
                end
                if (chk_spacing && out_data[31:16] == 16'hA55A) begin
                    if (last_hdr_cyc >= 0) begin
                        n_cmp++;
                        if (cyc - last_hdr_cyc != 100) begin
                            n_err++;
                            $display("FAIL hdr_spacing: got %0d required 100",
                                     cyc - last_hdr_cyc);
                        end
                    end
                    last_hdr_cyc = cyc;
                    hdr_cnt++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] s);
        logic [31:0] w;
        logic [31:0] x;
        logic [63:0] d;
        w = {16'hA55A, s, 8'(NC)};
        x = w;
        sb_q.push_back(w);
        for (int a = 0; a < int'(NC); a++) begin
            d = {32'(a) + 32'h100, 32'(a)} ^ flip_mask;
            sb_q.push_back(d[31:0]);
            sb_q.push_back(d[63:32]);
            x = x ^ d[31:0] ^ d[63:32];
        end
`ifdef PMU_SAMPLER_CHECKSUM_EN
        sb_q.push_back(x);
`endif
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        wait_cycles(1);
        trigger = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            wait_cycles(1);
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: busy=%b required 0", name, busy);
        end
        wait_cycles(2);
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d words left required 0", name, sb_q.size());
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || pmu_addr !== 5'd0 ||
            busy !== 1'b0 || overrun !== 1'b0 || seq !== 8'd0) begin
            n_err++;
            $display("FAIL reset_state: v=%b d=%h a=%0d b=%b o=%b s=%0d required all zero",
                     out_valid, out_data, pmu_addr, busy, overrun, seq);
        end
    endtask

    task automatic test_single_trigger();
        int busy_cnt;
        busy_cnt = 0;
        words_seen = 0;
        push_frame(exp_seq);
        pulse_trigger();
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (busy) busy_cnt++;
        end
        wait_cycles(1);
        exp_seq++;
        n_cmp++;
        if (busy_cnt != 1 + 3 * int'(NC)) begin
            n_err++;
            $display("FAIL busy_cycles: got %0d required %0d", busy_cnt, 1 + 3 * NC);
        end
        n_cmp++;
        if (seq !== exp_seq) begin
            n_err++;
            $display("FAIL seq_incr: got %0d required %0d", seq, exp_seq);
        end
        n_cmp++;
        if (words_seen != FrameLen) begin
            n_err++;
            $display("FAIL frame_len: got %0d required %0d", words_seen, FrameLen);
        end
        check_drained("single");
    endtask

    task automatic test_backpressure();
        words_seen = 0;
        push_frame(exp_seq);
        pulse_trigger();
        for (int i = 0; i < 600 && busy; i++) begin
            out_ready = (i % 3 == 0);
            wait_cycles(1);
        end
        out_ready = 1'b1;
        wait_idle("backpressure");
        exp_seq++;
        n_cmp++;
        if (words_seen != FrameLen) begin
            n_err++;
            $display("FAIL bp_frame_len: got %0d required %0d", words_seen, FrameLen);
        end
        check_drained("backpressure");
    endtask

    task automatic test_periodic();
        for (int f = 0; f < 10; f++) push_frame(exp_seq + 8'(f));
        hdr_cnt = 0;
        last_hdr_cyc = -1;
        chk_spacing = 1'b1;
        period = 32'd100;
        wait_cycles(1030);
        period = '0;
        wait_idle("periodic");
        chk_spacing = 1'b0;
        exp_seq += 8'd10;
        n_cmp++;
        if (hdr_cnt != 10) begin
            n_err++;
            $display("FAIL periodic_headers: got %0d required 10", hdr_cnt);
        end
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL periodic_overrun: got %b required 0", overrun);
        end
        check_drained("periodic");
    endtask

    task automatic test_overrun();
        // Ticks at +40k; frames start at +40 and +120, ticks at +80/+160 are lost.
        push_frame(exp_seq);
        push_frame(exp_seq + 8'd1);
        period = 32'd40;
        wait_cycles(60);
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_early: got %b required 0", overrun);
        end
        wait_cycles(25);
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_set: got %b required 1", overrun);
        end
        clear = 1'b1;
        wait_cycles(1);
        clear = 1'b0;
        wait_cycles(4);
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_clear: got %b required 0", overrun);
        end
        wait_cycles(69);
        clear = 1'b1;
        wait_cycles(1);
        clear = 1'b0;
        period = '0;
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_set_beats_clear: got %b required 1", overrun);
        end
        wait_idle("overrun");
        exp_seq += 8'd2;
        n_cmp++;
        if (seq !== exp_seq) begin
            n_err++;
            $display("FAIL overrun_seq: got %0d required %0d", seq, exp_seq);
        end
        check_drained("overrun");
        clear = 1'b1;
        wait_cycles(1);
        clear = 1'b0;
    endtask

    task automatic test_trigger_and_tick();
        push_frame(exp_seq);
        period = 32'd20;
        wait_cycles(19);
        trigger = 1'b1;
        wait_cycles(1);
        trigger = 1'b0;
        period = '0;
        wait_cycles(10);
        pulse_trigger();
        wait_idle("coincident");
        exp_seq++;
        wait_cycles(10);
        n_cmp++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL coincident_single: busy=%b overrun=%b required 0 0", busy, overrun);
        end
        n_cmp++;
        if (seq !== exp_seq) begin
            n_err++;
            $display("FAIL coincident_seq: got %0d required %0d", seq, exp_seq);
        end
        check_drained("coincident");
    endtask

    task automatic test_reset_mid_frame();
        int n;
        push_frame(exp_seq);
        pulse_trigger();
        n = 0;
        while (!(out_valid && out_data == 32'h107) && n < 200) begin
            wait_cycles(1);
            n++;
        end
        n_cmp++;
        if (!(out_valid && out_data == 32'h107)) begin
            n_err++;
            $display("FAIL reach_hi7: data=%h required 00000107", out_data);
        end
        areset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: valid=%b busy=%b required 0 0", out_valid, busy);
        end
        sb_q.delete();
        exp_seq = '0;
        wait_cycles(3);
        areset = 1'b0;
        wait_cycles(2);
        words_seen = 0;
        push_frame(exp_seq);
        pulse_trigger();
        wait_idle("post_reset");
        exp_seq++;
        n_cmp++;
        if (words_seen != FrameLen) begin
            n_err++;
            $display("FAIL post_reset_len: got %0d required %0d", words_seen, FrameLen);
        end
        check_drained("post_reset");
    endtask

    task automatic test_flipped_data();
        // Trailer (when present) must track the flipped bit; data words always do.
        flip_mask = 64'h0000_0020_0000_0000;
        push_frame(exp_seq);
        pulse_trigger();
        wait_idle("flip");
        exp_seq++;
        flip_mask = '0;
        check_drained("flip");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #23;
        test_reset();
        areset = 1'b0;
        wait_cycles(2);
        test_reset();
        test_single_trigger();
        test_backpressure();
        test_periodic();
        test_overrun();
        test_trigger_and_tick();
        test_reset_mid_frame();
        test_flipped_data();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
